// File: rtl/bit_besleyici_pkg.sv
// Shared types and sizing for the serial bit source.
package bit_besleyici_pkg;

   // Default maximum pattern length in bits.
   localparam int GENISLIK_VARSAYILAN = 16;

   // Stream controller states: idle, streaming, one-cycle end marker.
   typedef enum logic [1:0] {
      BOS    = 2'd0,
      GONDER = 2'd1,
      BITIS  = 2'd2
   } durum_e;

   // Width needed to hold a bit count from 0 up to and including genislik.
   function automatic int sayac_genisligi(input int genislik);
      return $clog2(genislik + 1);
   endfunction

endpackage

// File: rtl/doygun_sayac.sv
// Saturating event counter: counts enabled cycles and sticks at all-ones.
module doygun_sayac #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         en,
   output logic [W-1:0] deger
);

   // Count one per enabled cycle until the counter reaches its maximum.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values, independent of block evaluation order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         deger <= '0;
      end else if (en && (deger != '1)) begin
         deger <= deger + 1'b1;
      end
   end

endmodule

// File: rtl/bit_besleyici.sv
// Serial bit source: loads a word plus a length, then emits the bits
// MSB-first over valid/ready, with early abort from the consumer.
// The serial output is named seri_bit because `bit` is a reserved word.
module bit_besleyici
   import bit_besleyici_pkg::*;
#(
   parameter int GENISLIK = GENISLIK_VARSAYILAN,
   parameter int SAYAC_W  = sayac_genisligi(GENISLIK)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                yukle_gecerli,
   output logic                yukle_hazir,
   input  logic [GENISLIK-1:0] veri,
   input  logic [SAYAC_W-1:0]  uzunluk,
   input  logic                durdur,
   output logic                seri_bit,
   output logic                bit_gecerli,
   input  logic                bit_hazir,
   output logic [SAYAC_W-1:0]  kalan,
   output logic [7:0]          gonderilen,
   output logic                bitti,
   output logic                hata
);

   durum_e                durum_q, durum_d;
   logic [GENISLIK-1:0]   kaydirici;
   logic [SAYAC_W-1:0]    kalan_q;
   logic                  hata_q;

   logic                  yukle_ok;
   logic                  uzunluk_gecersiz;
   logic                  aktarim;
   logic [SAYAC_W-1:0]    kaydirma;

   assign yukle_ok         = yukle_gecerli && yukle_hazir;
   assign uzunluk_gecersiz = (uzunluk == '0) || (uzunluk > SAYAC_W'(GENISLIK));
   assign aktarim          = bit_gecerli && bit_hazir;
   // Left shift that puts bit [uzunluk-1] at the MSB of the shift register.
   assign kaydirma         = SAYAC_W'(GENISLIK) - uzunluk;

   // Outputs are decoded from registered state; only yukle_hazir sees durdur.
   assign yukle_hazir = (durum_q == BOS) && !durdur;
   assign bit_gecerli = (durum_q == GONDER);
   assign seri_bit    = bit_gecerli && kaydirici[GENISLIK-1];
   assign bitti       = (durum_q == BITIS);
   assign kalan       = kalan_q;
   assign hata        = hata_q;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         durum_q <= BOS;
      end else begin
         durum_q <= durum_d;
      end
   end

   // Next-state logic: last accepted bit or an abort ends the stream.
   // NOTE: durum_d gets a default before the case so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      durum_d = durum_q;
      case (durum_q)
         BOS: begin
            if (yukle_ok && !uzunluk_gecersiz) begin
               durum_d = GONDER;
            end
         end
         GONDER: begin
            if ((aktarim && (kalan_q == SAYAC_W'(1))) || durdur) begin
               durum_d = BITIS;
            end
         end
         BITIS:   durum_d = BOS;
         default: durum_d = BOS;
      endcase
   end

   // Shift register, remaining-bit count and rejected-load flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         kaydirici <= '0;
         kalan_q   <= '0;
         hata_q    <= 1'b0;
      end else begin
         hata_q <= yukle_ok && uzunluk_gecersiz;
         case (durum_q)
            BOS: begin
               if (yukle_ok && !uzunluk_gecersiz) begin
                  kaydirici <= veri << kaydirma;
                  kalan_q   <= uzunluk;
               end
            end
            GONDER: begin
               if (durum_d == BITIS) begin
                  // Normal end or abort: anything left over is discarded.
                  kaydirici <= '0;
                  kalan_q   <= '0;
               end else if (aktarim) begin
                  kaydirici <= {kaydirici[GENISLIK-2:0], 1'b0};
                  kalan_q   <= kalan_q - 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Total accepted bits since reset, saturating.
   doygun_sayac #(
      .W (8)
   ) u_gonderilen (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (aktarim),
      .deger (gonderilen)
   );

endmodule

// File: tb/tb_bit_besleyici.sv
// Bench for bit_besleyici: scoreboard of expected serial bits plus a
// table of loads and hand-written sequences for stall, abort and reset.
module tb_bit_besleyici;
   import bit_besleyici_pkg::*;

   localparam int G  = GENISLIK_VARSAYILAN;
   localparam int SW = sayac_genisligi(G);

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          yukle_gecerli = 1'b0;
   logic          yukle_hazir;
   logic [G-1:0]  veri = '0;
   logic [SW-1:0] uzunluk = '0;
   logic          durdur = 1'b0;
   logic          seri_bit;
   logic          bit_gecerli;
   logic          bit_hazir = 1'b1;
   logic [SW-1:0] kalan;
   logic [7:0]    gonderilen;
   logic          bitti;
   logic          hata;

   bit_besleyici dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .yukle_gecerli (yukle_gecerli),
      .yukle_hazir   (yukle_hazir),
      .veri          (veri),
      .uzunluk       (uzunluk),
      .durdur        (durdur),
      .seri_bit      (seri_bit),
      .bit_gecerli   (bit_gecerli),
      .bit_hazir     (bit_hazir),
      .kalan         (kalan),
      .gonderilen    (gonderilen),
      .bitti         (bitti),
      .hata          (hata)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_err    = 0;
   bit exp_q[$];
   int exp_cnt  = 0;

   typedef struct {
      logic [G-1:0] veri;
      int           uzunluk;
      logic         exp_hata;
   } vek_t;

   vek_t tablo[6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Called in the sampling window after a falling edge: scores the transfer
   // the next rising edge will make, then advances to the next falling edge.
   task automatic cyc();
      bit e;
      if (bit_gecerli && bit_hazir) begin
         check("sb_nonempty", exp_q.size() != 0, 1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("bit_order", seri_bit, e);
         end
         if (exp_cnt < 255) exp_cnt++;
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_load(input logic [G-1:0] v, input int len);
      check("load_ready", yukle_hazir, 1);
      veri          = v;
      uzunluk       = SW'(len);
      yukle_gecerli = 1'b1;
      if (len >= 1 && len <= G) begin
         for (int i = len - 1; i >= 0; i--) exp_q.push_back(v[i]);
      end
      cyc();
      yukle_gecerli = 1'b0;
   endtask

   task automatic wait_bitti(input int budget, output int cycles);
      cycles = 0;
      while (!bitti && cycles < budget) begin
         cyc();
         cycles++;
      end
      check("bitti_within_budget", bitti, 1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not reach the summary");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int c;
      int k;
      int base;

      tablo[0] = '{16'h1234, 0,  1'b1};
      tablo[1] = '{16'hFFFF, 17, 1'b1};
      tablo[2] = '{16'h8001, 16, 1'b0};
      tablo[3] = '{16'h0001, 1,  1'b0};
      tablo[4] = '{16'h0000, 1,  1'b0};
      tablo[5] = '{16'h5A3C, 9,  1'b0};

      // Reset values.
      @(negedge clk);
      check("rst_valid", bit_gecerli, 0);
      check("rst_bit", seri_bit, 0);
      check("rst_kalan", kalan, 0);
      check("rst_gonderilen", gonderilen, 0);
      check("rst_bitti", bitti, 0);
      check("rst_hata", hata, 0);
      check("rst_ready", yukle_hazir, 1);
      durdur = 1'b1;
      #1;
      check("rst_ready_durdur", yukle_hazir, 0);
      durdur = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Basic length-4 stream with the consumer always ready.
      do_load(16'h000B, 4);
      for (int i = 0; i < 4; i++) begin
         check("t1_valid", bit_gecerli, 1);
         check("t1_kalan", kalan, 4 - i);
         cyc();
      end
      check("t1_bitti", bitti, 1);
      check("t1_valid_end", bit_gecerli, 0);
      check("t1_kalan_end", kalan, 0);
      check("t1_gonderilen", gonderilen, 4);
      check("t1_sb_empty", exp_q.size(), 0);
      cyc();
      check("t1_bitti_pulse", bitti, 0);
      check("t1_ready_again", yukle_hazir, 1);

      // Stall: consumer not ready for cycles N+2..N+4.
      do_load(16'h000B, 4);
      k = 1;
      while (!bitti && k < 20) begin
         bit_hazir = !(k >= 2 && k <= 4);
         if (k >= 2 && k <= 4) begin
            check("t2_hold_bit", seri_bit, 0);
            check("t2_hold_kalan", kalan, 3);
         end
         cyc();
         k++;
      end
      bit_hazir = 1'b1;
      check("t2_end_cycle", k, 8);
      check("t2_bitti", bitti, 1);
      check("t2_sb_empty", exp_q.size(), 0);
      check("t2_gonderilen", gonderilen, exp_cnt);
      cyc();

      // Abort at N+2 of a length-8 stream.
      base = exp_cnt;
      do_load(16'h00A5, 8);
      cyc();
      durdur = 1'b1;
      cyc();
      check("t3_bitti", bitti, 1);
      check("t3_valid", bit_gecerli, 0);
      check("t3_kalan", kalan, 0);
      check("t3_gonderilen", gonderilen, base + 2);
      check("t3_discarded", exp_q.size(), 6);
      exp_q.delete();
      cyc();
      check("t3_ready_low", yukle_hazir, 0);
      veri          = 16'h000F;
      uzunluk       = SW'(4);
      yukle_gecerli = 1'b1;
      cyc();
      check("t3_no_load", bit_gecerli, 0);
      check("t3_no_hata", hata, 0);
      yukle_gecerli = 1'b0;
      durdur        = 1'b0;
      #1;
      check("t3_ready_back", yukle_hazir, 1);

      // Table of loads: rejected lengths and legal boundary lengths.
      foreach (tablo[t]) begin
         do_load(tablo[t].veri, tablo[t].uzunluk);
         if (tablo[t].exp_hata) begin
            check("tab_hata", hata, 1);
            check("tab_hata_valid", bit_gecerli, 0);
            check("tab_hata_ready", yukle_hazir, 1);
            cyc();
            check("tab_hata_pulse", hata, 0);
            check("tab_hata_valid2", bit_gecerli, 0);
         end else begin
            check("tab_hata_none", hata, 0);
            wait_bitti(tablo[t].uzunluk + 2, c);
            check("tab_len_cycles", c, tablo[t].uzunluk);
            check("tab_sb_empty", exp_q.size(), 0);
            check("tab_gonderilen", gonderilen, exp_cnt);
            cyc();
         end
      end

      // Sixteen back-to-back length-16 words: counter saturates.
      for (int w = 0; w < 16; w++) begin
         do_load(G'($urandom), 16);
         wait_bitti(18, c);
         check("t5_len_cycles", c, 16);
         cyc();
      end
      check("t5_sb_empty", exp_q.size(), 0);
      check("t5_model", gonderilen, exp_cnt);
      check("t5_saturated", gonderilen, 255);

      // Reset in the middle of a stream.
      do_load(16'hFFFF, 8);
      cyc();
      cyc();
      rst_n = 1'b0;
      #1;
      check("t6_valid", bit_gecerli, 0);
      check("t6_bit", seri_bit, 0);
      check("t6_kalan", kalan, 0);
      check("t6_gonderilen", gonderilen, 0);
      check("t6_bitti", bitti, 0);
      check("t6_hata", hata, 0);
      check("t6_ready", yukle_hazir, 1);
      exp_q.delete();
      exp_cnt = 0;
      @(posedge clk);
      @(negedge clk);
      check("t6_no_bitti", bitti, 0);
      rst_n = 1'b1;
      cyc();
      do_load(16'h000B, 4);
      wait_bitti(6, c);
      check("t6_len_cycles", c, 4);
      check("t6_gonderilen_after", gonderilen, 4);
      check("t6_sb_empty", exp_q.size(), 0);
      cyc();

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
